vfu_wb_arbiter: RTL and testbench
=================================

# vfu_wb_arbiter

Writeback arbiter between a lane's functional units and the lane's vector register file write port. It accepts the ALU and MFPU result request/grant interfaces (the FUs drive `req`/`addr`/`wdata`/`be`/`id` and wait for `gnt`) and merges them onto a single registered valid/ready write channel toward the VRF bank logic. It applies round-robin fairness and drops all-zero-strobe writes. One instance sits in each lane.

## Interface
- `vaddr_t`, default `logic`: VRF element address type.
- `DataWidth`, localparam, `$bits(elen_t)`: write data width.
- `strb_t`, localparam, `logic [DataWidth/8-1:0]`: byte-enable type.
- Clock and reset: one clock; reset is synchronous and active-low (`clk_i`, `rst_ni`).
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous active-low reset.
- `alu_result_req_i` in 1: ALU write request; held with payload until granted.
- `alu_result_id_i` in `vid_t`: ALU instruction id.
- `alu_result_addr_i` in `vaddr_t`: ALU write address.
- `alu_result_wdata_i` in `elen_t`: ALU write data.
- `alu_result_be_i` in `strb_t`: ALU byte enables.
- `alu_result_gnt_o` out 1: ALU request accepted this cycle.
- `mfpu_result_req_i`, `mfpu_result_id_i`, `mfpu_result_addr_i`, `mfpu_result_wdata_i`, `mfpu_result_be_i`, `mfpu_result_gnt_o`: same as the ALU ports, for the MFPU.
- `vrf_valid_o` out 1: registered write valid.
- `vrf_ready_i` in 1: VRF accepts the write.
- `vrf_id_o` out `vid_t`, `vrf_addr_o` out `vaddr_t`, `vrf_wdata_o` out `elen_t`, `vrf_be_o` out `strb_t`: registered payload.
- `vrf_src_o` out `vfu_wb_src_e`: FU that originated the registered write.

## Operation
- One-entry output register: `out_valid_q` plus the payload.
- The register is free when `!out_valid_q || vrf_ready_i`.
- Grant is combinational in the same cycle as `req`. At most one `gnt` is high per cycle, and only while the register is free.
- Arbitration, one requester: that requester is granted.
- Arbitration, both requesting: grant the FU that `rr_q` points to.
- `rr_q` update: after every grant, `rr_q` points to the FU that was not granted. Reset value is `WbSrcAlu`.
- Granted with `be != 0`: load the payload and `src` into the register and set `out_valid_q`.
- Granted with `be == 0`: the request is consumed (`gnt` asserted) and nothing is loaded. `out_valid_q` becomes 0 if it is draining this cycle, otherwise it is unchanged. `rr_q` still updates.
- No grant and `vrf_ready_i`: clear `out_valid_q`.
- While the register is held (`out_valid_q && !vrf_ready_i`), the payload is stable and both grants are 0.
- Reset: `out_valid_q`=0, payload=0, `src`=`WbSrcAlu`, `rr_q`=`WbSrcAlu`. Both `gnt` outputs are 0 because they are qualified by the reset state. Requests that are pending during reset are not granted.

## Timing
- Latency: a grant in cycle N gives `vrf_valid_o`=1 in cycle N+1.
- Throughput: 1 write per cycle. Grant and drain can happen in the same cycle, so there are no bubbles.
- `vrf_valid_o` is never deasserted, and the payload never changes, until `vrf_ready_i` is seen high.
- Simultaneous requests: the two FUs alternate every cycle while both keep requesting. Neither waits more than 1 grant.
- `gnt` depends combinationally on `req`, `rr_q`, `out_valid_q` and `vrf_ready_i`. There is no combinational path from `addr`, `wdata` or `id` to `gnt`.
- Reset mid-transfer: the held write is discarded, and the FUs keep their requests asserted.

## Structure
- Add `typedef enum logic {WbSrcAlu, WbSrcMfpu} vfu_wb_src_e` to `ara_pkg`.
- `vid_t`, `elen_t` and `NrVInsn` are reused from `ara_pkg`.
- Sub-module: `vfu_wb_rr_pick`, a 2-way round-robin pick with pointer update. The payload mux and output register are inline.

## Test plan
- Single ALU write: `addr`=0x10, `wdata`=0xDEADBEEF, `be`=0xFF, `vrf_ready_i`=1 → `alu_result_gnt_o`=1 in cycle 0; in cycle 1 `vrf_valid_o`=1, `vrf_addr_o`=0x10, `vrf_src_o`=`WbSrcAlu`.
- Both FUs requesting 4 writes each, `vrf_ready_i`=1 → grants alternate ALU, MFPU, ALU, MFPU… starting from ALU after reset; 8 writes in 8 consecutive cycles.
- Backpressure: `vrf_ready_i`=0 for 5 cycles while valid → `vrf_valid_o` and payload stable, both `gnt`=0; on release the next request is granted in the same cycle.
- Zero strobe: MFPU `be`=0 → `mfpu_result_gnt_o`=1, no `vrf_valid_o` pulse; `rr_q` flips to ALU.
- Reset asserted for 1 cycle while `vrf_valid_o`=1 and held → next cycle `vrf_valid_o`=0 and `rr_q`=ALU; a pending MFPU request is granted in the first cycle after reset.
- Random requests and stalls (10k cycles) → scoreboard: every write with `be != 0` appears exactly once and in grant order; no write is lost or duplicated.

Source files
------------

// File: rtl/vfu_wb_arbiter_pkg.sv
// vfu_wb_arbiter_pkg: shared types for the lane writeback arbiter.
package vfu_wb_arbiter_pkg;
    localparam int unsigned NrVInsn = 8;
    localparam int unsigned ELEN = 64;
    typedef logic [ELEN-1:0] elen_t;
    typedef logic [$clog2(NrVInsn)-1:0] vid_t;
    localparam int unsigned DataWidth = $bits(elen_t);
    typedef logic [DataWidth/8-1:0] strb_t;
    typedef enum logic {WbSrcAlu, WbSrcMfpu} vfu_wb_src_e;
endpackage

// File: rtl/vfu_wb_arbiter_if.sv
// vfu_wb_arbiter_if: FU result req/gnt ports plus the VRF valid/ready write channel.
interface vfu_wb_arbiter_if import vfu_wb_arbiter_pkg::*; #(parameter type vaddr_t = logic) ();
    logic        alu_result_req_i;
    vid_t        alu_result_id_i;
    vaddr_t      alu_result_addr_i;
    elen_t       alu_result_wdata_i;
    strb_t       alu_result_be_i;
    logic        alu_result_gnt_o;
    logic        mfpu_result_req_i;
    vid_t        mfpu_result_id_i;
    vaddr_t      mfpu_result_addr_i;
    elen_t       mfpu_result_wdata_i;
    strb_t       mfpu_result_be_i;
    logic        mfpu_result_gnt_o;
    logic        vrf_valid_o;
    logic        vrf_ready_i;
    vid_t        vrf_id_o;
    vaddr_t      vrf_addr_o;
    elen_t       vrf_wdata_o;
    strb_t       vrf_be_o;
    vfu_wb_src_e vrf_src_o;
    modport slave (
        input  alu_result_req_i, alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i,
        input  mfpu_result_req_i, mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i,
        input  vrf_ready_i,
        output alu_result_gnt_o, mfpu_result_gnt_o,
        output vrf_valid_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o, vrf_src_o
    );
    modport master (
        output alu_result_req_i, alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i,
        output mfpu_result_req_i, mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i,
        output vrf_ready_i,
        input  alu_result_gnt_o, mfpu_result_gnt_o,
        input  vrf_valid_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o, vrf_src_o
    );
endinterface

// File: rtl/vfu_wb_rr_pick.sv
// vfu_wb_rr_pick: 2-way round-robin pick; the pointer always moves to the loser of the last grant.
module vfu_wb_rr_pick import vfu_wb_arbiter_pkg::*; (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic free_i,
    input  logic req_alu_i,
    input  logic req_mfpu_i,
    output logic gnt_alu_o,
    output logic gnt_mfpu_o
);
    vfu_wb_src_e rr_q, rr_d;
    always_comb begin
        gnt_alu_o  = free_i && req_alu_i && (!req_mfpu_i || rr_q == WbSrcAlu);
        gnt_mfpu_o = free_i && req_mfpu_i && (!req_alu_i || rr_q == WbSrcMfpu);
        rr_d       = gnt_alu_o ? WbSrcMfpu : gnt_mfpu_o ? WbSrcAlu : rr_q;
    end
    always_ff @(posedge clk_i) begin
        rr_q <= !rst_ni ? WbSrcAlu : rr_d;
    end
endmodule

// File: rtl/vfu_wb_arbiter.sv
// vfu_wb_arbiter: merges ALU/MFPU result requests onto one registered VRF write channel,
// round-robin between FUs and dropping all-zero-strobe writes.
module vfu_wb_arbiter import vfu_wb_arbiter_pkg::*; #(parameter type vaddr_t = logic) (
    input logic clk_i,
    input logic rst_ni,
    vfu_wb_arbiter_if.slave bus
);
    logic        free, gnt_alu, gnt_mfpu, load;
    logic        valid_q, valid_d;
    vid_t        id_q, id_d;
    vaddr_t      addr_q, addr_d;
    elen_t       wdata_q, wdata_d;
    strb_t       be_q, be_d;
    vfu_wb_src_e src_q, src_d;
    // Reset gates the grant so requests pending during reset are left untouched.
    assign free = rst_ni && (!valid_q || bus.vrf_ready_i);
    vfu_wb_rr_pick i_pick (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .free_i     (free),
        .req_alu_i  (bus.alu_result_req_i),
        .req_mfpu_i (bus.mfpu_result_req_i),
        .gnt_alu_o  (gnt_alu),
        .gnt_mfpu_o (gnt_mfpu)
    );
    always_comb begin
        load    = (gnt_alu && |bus.alu_result_be_i) || (gnt_mfpu && |bus.mfpu_result_be_i);
        valid_d = load || (valid_q && !bus.vrf_ready_i);
        src_d   = !load ? src_q : gnt_mfpu ? WbSrcMfpu : WbSrcAlu;
        id_d    = !load ? id_q : gnt_mfpu ? bus.mfpu_result_id_i : bus.alu_result_id_i;
        addr_d  = !load ? addr_q : gnt_mfpu ? bus.mfpu_result_addr_i : bus.alu_result_addr_i;
        wdata_d = !load ? wdata_q : gnt_mfpu ? bus.mfpu_result_wdata_i : bus.alu_result_wdata_i;
        be_d    = !load ? be_q : gnt_mfpu ? bus.mfpu_result_be_i : bus.alu_result_be_i;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            src_q   <= WbSrcAlu;
            id_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            valid_q <= valid_d;
            src_q   <= src_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end
    assign bus.alu_result_gnt_o  = gnt_alu;
    assign bus.mfpu_result_gnt_o = gnt_mfpu;
    assign bus.vrf_valid_o       = valid_q;
    assign bus.vrf_src_o         = src_q;
    assign bus.vrf_id_o          = id_q;
    assign bus.vrf_addr_o        = addr_q;
    assign bus.vrf_wdata_o       = wdata_q;
    assign bus.vrf_be_o          = be_q;
endmodule

// File: tb/tb_vfu_wb_arbiter.sv
// tb_vfu_wb_arbiter: directed scenarios plus a randomized scoreboard run for the writeback arbiter.
module tb_vfu_wb_arbiter;
    import vfu_wb_arbiter_pkg::*;
    typedef logic [15:0] addr_t;
    typedef logic [1+$bits(vid_t)+$bits(strb_t)+$bits(elen_t)+16-1:0] ent_t;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int checks = 0;
    int errors = 0;
    vfu_wb_arbiter_if #(.vaddr_t(addr_t)) bus ();
    vfu_wb_arbiter #(.vaddr_t(addr_t)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
    always #5 clk_i = ~clk_i;

    task automatic idle();
        bus.alu_result_req_i   = 1'b0;
        bus.alu_result_id_i    = '0;
        bus.alu_result_addr_i  = '0;
        bus.alu_result_wdata_i = '0;
        bus.alu_result_be_i    = '0;
        bus.mfpu_result_req_i   = 1'b0;
        bus.mfpu_result_id_i    = '0;
        bus.mfpu_result_addr_i  = '0;
        bus.mfpu_result_wdata_i = '0;
        bus.mfpu_result_be_i    = '0;
    endtask

    task automatic set_alu(input logic req, input addr_t a, input elen_t d, input strb_t be, input vid_t id);
        bus.alu_result_req_i   = req;
        bus.alu_result_addr_i  = a;
        bus.alu_result_wdata_i = d;
        bus.alu_result_be_i    = be;
        bus.alu_result_id_i    = id;
    endtask

    task automatic set_mfpu(input logic req, input addr_t a, input elen_t d, input strb_t be, input vid_t id);
        bus.mfpu_result_req_i   = req;
        bus.mfpu_result_addr_i  = a;
        bus.mfpu_result_wdata_i = d;
        bus.mfpu_result_be_i    = be;
        bus.mfpu_result_id_i    = id;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle();
        bus.vrf_ready_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        bus.vrf_ready_i = 1'b1;
        set_alu(1'b1, 16'h1, 64'h1, 8'hFF, 3'd1);
        set_mfpu(1'b1, 16'h2, 64'h2, 8'hFF, 3'd2);
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (bus.alu_result_gnt_o !== 1'b0 || bus.mfpu_result_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt got %b%b exp 00", bus.alu_result_gnt_o, bus.mfpu_result_gnt_o);
        end
        checks++;
        if (bus.vrf_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", bus.vrf_valid_o);
        end
        checks++;
        if (bus.vrf_addr_o !== 16'h0 || bus.vrf_wdata_o !== 64'h0 || bus.vrf_src_o !== WbSrcAlu) begin
            errors++;
            $display("FAIL reset_payload got %h %h %b exp 0 0 0", bus.vrf_addr_o, bus.vrf_wdata_o, bus.vrf_src_o);
        end
        idle();
        rst_ni = 1'b1;
    endtask

    task automatic test_single_alu();
        do_reset();
        bus.vrf_ready_i = 1'b1;
        set_alu(1'b1, 16'h10, 64'hDEADBEEF, 8'hFF, 3'd3);
        #1;
        checks++;
        if (bus.alu_result_gnt_o !== 1'b1 || bus.mfpu_result_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt got %b%b exp 10", bus.alu_result_gnt_o, bus.mfpu_result_gnt_o);
        end
        @(negedge clk_i);
        idle();
        checks++;
        if (bus.vrf_valid_o !== 1'b1 || bus.vrf_addr_o !== 16'h10 || bus.vrf_src_o !== WbSrcAlu) begin
            errors++;
            $display("FAIL single_out got v=%b a=%h s=%b exp v=1 a=0010 s=0", bus.vrf_valid_o, bus.vrf_addr_o, bus.vrf_src_o);
        end
        checks++;
        if (bus.vrf_wdata_o !== 64'hDEADBEEF || bus.vrf_be_o !== 8'hFF || bus.vrf_id_o !== 3'd3) begin
            errors++;
            $display("FAIL single_payload got %h %h %h exp deadbeef ff 3", bus.vrf_wdata_o, bus.vrf_be_o, bus.vrf_id_o);
        end
        @(negedge clk_i);
        checks++;
        if (bus.vrf_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got %b exp 0", bus.vrf_valid_o);
        end
    endtask

    task automatic test_alternate();
        int ai = 0;
        int mi = 0;
        logic exp_alu;
        addr_t exp_addr;
        do_reset();
        bus.vrf_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            set_alu(ai < 4, addr_t'(16'h100 + ai), elen_t'(c), 8'hFF, 3'd0);
            set_mfpu(mi < 4, addr_t'(16'h200 + mi), elen_t'(c), 8'hFF, 3'd1);
            exp_alu = (c % 2) == 0;
            exp_addr = exp_alu ? addr_t'(16'h100 + ai) : addr_t'(16'h200 + mi);
            #1;
            checks++;
            if (bus.alu_result_gnt_o !== exp_alu || bus.mfpu_result_gnt_o !== !exp_alu) begin
                errors++;
                $display("FAIL alt_gnt c=%0d got %b%b exp %b%b", c, bus.alu_result_gnt_o, bus.mfpu_result_gnt_o, exp_alu, !exp_alu);
            end
            if (exp_alu) ai++;
            else mi++;
            @(negedge clk_i);
            checks++;
            if (bus.vrf_valid_o !== 1'b1 || bus.vrf_addr_o !== exp_addr || bus.vrf_src_o !== (exp_alu ? WbSrcAlu : WbSrcMfpu)) begin
                errors++;
                $display("FAIL alt_out c=%0d got v=%b a=%h s=%b exp v=1 a=%h s=%b", c, bus.vrf_valid_o, bus.vrf_addr_o, bus.vrf_src_o, exp_addr, !exp_alu);
            end
        end
        idle();
        @(negedge clk_i);
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.vrf_ready_i = 1'b1;
        set_alu(1'b1, 16'h30, 64'h1, 8'h0F, 3'd2);
        #1;
        checks++;
        if (bus.alu_result_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_gnt got %b exp 1", bus.alu_result_gnt_o);
        end
        @(negedge clk_i);
        set_alu(1'b1, 16'h31, 64'h2, 8'hFF, 3'd2);
        set_mfpu(1'b1, 16'h40, 64'h3, 8'hFF, 3'd4);
        bus.vrf_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus.alu_result_gnt_o !== 1'b0 || bus.mfpu_result_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_gnt k=%0d got %b%b exp 00", k, bus.alu_result_gnt_o, bus.mfpu_result_gnt_o);
            end
            checks++;
            if (bus.vrf_valid_o !== 1'b1 || bus.vrf_addr_o !== 16'h30 || bus.vrf_be_o !== 8'h0F || bus.vrf_wdata_o !== 64'h1) begin
                errors++;
                $display("FAIL bp_hold_out k=%0d got v=%b a=%h be=%h exp v=1 a=0030 be=0f", k, bus.vrf_valid_o, bus.vrf_addr_o, bus.vrf_be_o);
            end
            @(negedge clk_i);
        end
        bus.vrf_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.alu_result_gnt_o !== 1'b0 || bus.mfpu_result_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_gnt got %b%b exp 01", bus.alu_result_gnt_o, bus.mfpu_result_gnt_o);
        end
        @(negedge clk_i);
        set_mfpu(1'b0, 16'h0, 64'h0, 8'h0, 3'd0);
        checks++;
        if (bus.vrf_valid_o !== 1'b1 || bus.vrf_addr_o !== 16'h40 || bus.vrf_src_o !== WbSrcMfpu) begin
            errors++;
            $display("FAIL bp_release_out got v=%b a=%h s=%b exp v=1 a=0040 s=1", bus.vrf_valid_o, bus.vrf_addr_o, bus.vrf_src_o);
        end
        #1;
        checks++;
        if (bus.alu_result_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_gnt got %b exp 1", bus.alu_result_gnt_o);
        end
        @(negedge clk_i);
        idle();
        checks++;
        if (bus.vrf_valid_o !== 1'b1 || bus.vrf_addr_o !== 16'h31) begin
            errors++;
            $display("FAIL bp_next_out got v=%b a=%h exp v=1 a=0031", bus.vrf_valid_o, bus.vrf_addr_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_zero_strobe();
        do_reset();
        bus.vrf_ready_i = 1'b1;
        set_alu(1'b1, 16'h50, 64'h5, 8'hFF, 3'd0);
        @(negedge clk_i);
        set_alu(1'b0, 16'h0, 64'h0, 8'h0, 3'd0);
        set_mfpu(1'b1, 16'h55, 64'h6, 8'h00, 3'd1);
        #1;
        checks++;
        if (bus.mfpu_result_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL zs_gnt got %b exp 1", bus.mfpu_result_gnt_o);
        end
        @(negedge clk_i);
        checks++;
        if (bus.vrf_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zs_no_valid got %b exp 0", bus.vrf_valid_o);
        end
        set_alu(1'b1, 16'h51, 64'h7, 8'hFF, 3'd0);
        set_mfpu(1'b1, 16'h60, 64'h8, 8'hFF, 3'd1);
        #1;
        checks++;
        if (bus.alu_result_gnt_o !== 1'b1 || bus.mfpu_result_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL zs_rr got %b%b exp 10", bus.alu_result_gnt_o, bus.mfpu_result_gnt_o);
        end
        @(negedge clk_i);
        idle();
        checks++;
        if (bus.vrf_valid_o !== 1'b1 || bus.vrf_addr_o !== 16'h51) begin
            errors++;
            $display("FAIL zs_after got v=%b a=%h exp v=1 a=0051", bus.vrf_valid_o, bus.vrf_addr_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.vrf_ready_i = 1'b1;
        set_alu(1'b1, 16'h70, 64'h9, 8'hFF, 3'd0);
        @(negedge clk_i);
        set_alu(1'b0, 16'h0, 64'h0, 8'h0, 3'd0);
        set_mfpu(1'b1, 16'h80, 64'hA, 8'h03, 3'd5);
        bus.vrf_ready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (bus.mfpu_result_gnt_o !== 1'b0 || bus.vrf_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rm_during got gnt=%b v=%b exp gnt=0 v=1", bus.mfpu_result_gnt_o, bus.vrf_valid_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        checks++;
        if (bus.vrf_valid_o !== 1'b0 || bus.vrf_addr_o !== 16'h0 || bus.vrf_src_o !== WbSrcAlu) begin
            errors++;
            $display("FAIL rm_cleared got v=%b a=%h s=%b exp v=0 a=0000 s=0", bus.vrf_valid_o, bus.vrf_addr_o, bus.vrf_src_o);
        end
        #1;
        checks++;
        if (bus.mfpu_result_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rm_first_gnt got %b exp 1", bus.mfpu_result_gnt_o);
        end
        @(negedge clk_i);
        idle();
        checks++;
        if (bus.vrf_valid_o !== 1'b1 || bus.vrf_addr_o !== 16'h80 || bus.vrf_src_o !== WbSrcMfpu) begin
            errors++;
            $display("FAIL rm_out got v=%b a=%h s=%b exp v=1 a=0080 s=1", bus.vrf_valid_o, bus.vrf_addr_o, bus.vrf_src_o);
        end
        bus.vrf_ready_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t got, exp, snap;
        logic a_done = 1'b0;
        logic m_done = 1'b0;
        logic hold_prev = 1'b0;
        logic drain;
        do_reset();
        for (int cyc = 0; cyc < 10020; cyc++) begin
            drain = cyc >= 10000;
            bus.vrf_ready_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (a_done || !bus.alu_result_req_i)
                set_alu(!drain && $urandom_range(0, 2) != 0, addr_t'($urandom), {$urandom, $urandom},
                        $urandom_range(0, 3) == 0 ? 8'h00 : strb_t'($urandom), vid_t'($urandom));
            if (m_done || !bus.mfpu_result_req_i)
                set_mfpu(!drain && $urandom_range(0, 2) != 0, addr_t'($urandom), {$urandom, $urandom},
                         $urandom_range(0, 3) == 0 ? 8'h00 : strb_t'($urandom), vid_t'($urandom));
            a_done = 1'b0;
            m_done = 1'b0;
            #1;
            got = {bus.vrf_src_o, bus.vrf_id_o, bus.vrf_be_o, bus.vrf_wdata_o, bus.vrf_addr_o};
            if (hold_prev) begin
                checks++;
                if (bus.vrf_valid_o !== 1'b1 || got !== snap) begin
                    errors++;
                    $display("FAIL rand_hold cyc=%0d got v=%b %h exp v=1 %h", cyc, bus.vrf_valid_o, got, snap);
                end
            end
            if (bus.vrf_valid_o && !bus.vrf_ready_i) begin
                checks++;
                if (bus.alu_result_gnt_o !== 1'b0 || bus.mfpu_result_gnt_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_held_gnt cyc=%0d got %b%b exp 00", cyc, bus.alu_result_gnt_o, bus.mfpu_result_gnt_o);
                end
            end
            checks++;
            if (bus.alu_result_gnt_o === 1'b1 && bus.mfpu_result_gnt_o === 1'b1) begin
                errors++;
                $display("FAIL rand_two_gnt cyc=%0d got 11 exp at most one", cyc);
            end
            if (bus.vrf_valid_o === 1'b1 && bus.vrf_ready_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra cyc=%0d got %h exp no write", cyc, got);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL rand_write cyc=%0d got %h exp %h", cyc, got, exp);
                    end
                end
            end
            if (bus.alu_result_gnt_o === 1'b1) begin
                a_done = 1'b1;
                if (bus.alu_result_be_i != 0)
                    q.push_back({WbSrcAlu, bus.alu_result_id_i, bus.alu_result_be_i, bus.alu_result_wdata_i, bus.alu_result_addr_i});
            end
            if (bus.mfpu_result_gnt_o === 1'b1) begin
                m_done = 1'b1;
                if (bus.mfpu_result_be_i != 0)
                    q.push_back({WbSrcMfpu, bus.mfpu_result_id_i, bus.mfpu_result_be_i, bus.mfpu_result_wdata_i, bus.mfpu_result_addr_i});
            end
            snap = got;
            hold_prev = bus.vrf_valid_o && !bus.vrf_ready_i;
            @(negedge clk_i);
        end
        checks++;
        if (q.size() != 0 || bus.alu_result_req_i || bus.mfpu_result_req_i) begin
            errors++;
            $display("FAIL rand_lost got %0d pending exp 0", q.size());
        end
        idle();
    endtask

    initial begin
        idle();
        bus.vrf_ready_i = 1'b1;
        test_reset();
        test_single_alu();
        test_alternate();
        test_backpressure();
        test_zero_strobe();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
